// File: rtl/axis_waddr_arbiter.sv
// axis_waddr_arbiter: round-robin sharing of one AXI write address/data channel between NB_PORTS writers;
// an order FIFO of granted bursts steers write beats from the owning port in address issue order.
module axis_waddr_arbiter #(
   parameter int NB_PORTS       = 4,
   parameter int AXI_LEN_WIDTH  = 8,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 256,
   parameter int ORDER_LOG2     = 3
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NB_PORTS*AXI_ADDR_WIDTH-1:0]   req_aaddr,
   input  logic [NB_PORTS*AXI_LEN_WIDTH-1:0]    req_alen,
   input  logic [NB_PORTS-1:0]                  req_avalid,
   output logic [NB_PORTS-1:0]                  req_aready,
   input  logic [NB_PORTS*AXI_DATA_WIDTH-1:0]   req_wdata,
   input  logic [NB_PORTS-1:0]                  req_wvalid,
   output logic [NB_PORTS-1:0]                  req_wready,
   output logic [AXI_ADDR_WIDTH-1:0]            axi_aaddr,
   output logic [AXI_LEN_WIDTH-1:0]             axi_alen,
   output logic                                 axi_avalid,
   input  logic                                 axi_aready,
   output logic [AXI_DATA_WIDTH-1:0]            axi_wdata,
   output logic                                 axi_wlast,
   output logic                                 axi_wvalid,
   input  logic                                 axi_wready
);
   localparam int PW    = $clog2(NB_PORTS);
   localparam int DEPTH = 1 << ORDER_LOG2;
   localparam int CW    = ORDER_LOG2 + 1;

   typedef enum logic [1:0] {S_IDLE = 2'b01, S_ISSUE = 2'b10} state_t;

   state_t                       r_state;
   logic [PW-1:0]                r_last;
   logic [AXI_ADDR_WIDTH-1:0]    r_aaddr;
   logic [AXI_LEN_WIDTH-1:0]     r_alen;
   logic                         r_avalid;
   logic [PW+AXI_LEN_WIDTH-1:0]  r_mem [DEPTH];
   logic [ORDER_LOG2-1:0]        r_wp;
   logic [ORDER_LOG2-1:0]        r_rp;
   logic [CW-1:0]                r_count;
   logic [AXI_LEN_WIDTH-1:0]     r_beat;

   logic                         w_req_any;
   logic [PW-1:0]                w_idx;
   logic [PW-1:0]                w_win;
   logic                         w_grant;
   logic [AXI_ADDR_WIDTH-1:0]    w_gaddr;
   logic [AXI_LEN_WIDTH-1:0]     w_glen;
   logic                         w_push;
   logic                         w_pop;
   logic                         w_ne;
   logic [PW-1:0]                w_hport;
   logic [AXI_LEN_WIDTH-1:0]     w_hlen;

   // descending scan so the port nearest last_winner+1 is the final (winning) assignment
   always_comb begin
      w_req_any = 1'b0;
      w_win     = '0;
      w_idx     = '0;
      for (int k = NB_PORTS; k >= 1; k--) begin
         w_idx = PW'((int'(r_last) + k) % NB_PORTS);
         if (req_avalid[w_idx]) begin
            w_req_any = 1'b1;
            w_win     = w_idx;
         end
      end
   end

   always_comb begin
      w_gaddr = '0;
      w_glen  = '0;
      for (int p = 0; p < NB_PORTS; p++)
         if (w_win == PW'(p)) begin
            w_gaddr = req_aaddr[p*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            w_glen  = req_alen[p*AXI_LEN_WIDTH +: AXI_LEN_WIDTH];
         end
   end

   assign w_grant    = rst_n && (r_state == S_IDLE) && (r_count < CW'(DEPTH)) && w_req_any;
   assign req_aready = w_grant ? (NB_PORTS'(1'b1) << w_win) : '0;
   assign w_push     = (r_state == S_ISSUE) && axi_aready;
   assign w_ne       = (r_count != '0);
   assign {w_hport, w_hlen} = r_mem[r_rp];
   assign axi_wlast  = w_ne && (r_beat == w_hlen);
   assign w_pop      = axi_wvalid && axi_wready && axi_wlast;
   assign axi_aaddr  = r_aaddr;
   assign axi_alen   = r_alen;
   assign axi_avalid = r_avalid;

   always_comb begin
      axi_wdata  = '0;
      axi_wvalid = 1'b0;
      req_wready = '0;
      for (int p = 0; p < NB_PORTS; p++)
         if (w_ne && (w_hport == PW'(p))) begin
            axi_wdata     = req_wdata[p*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            axi_wvalid    = req_wvalid[p];
            req_wready[p] = axi_wready;
         end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_last   <= PW'(NB_PORTS - 1);
         r_aaddr  <= '0;
         r_alen   <= '0;
         r_avalid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE:
               if (w_grant) begin
                  r_state  <= S_ISSUE;
                  r_last   <= w_win;
                  r_aaddr  <= w_gaddr;
                  r_alen   <= w_glen;
                  r_avalid <= 1'b1;
               end
            S_ISSUE:
               if (axi_aready) begin
                  r_state  <= S_IDLE;
                  r_avalid <= 1'b0;
               end
            default: begin
               r_state  <= S_IDLE;
               r_avalid <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         r_beat  <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + ORDER_LOG2'(1);
         if (w_pop) r_rp <= r_rp + ORDER_LOG2'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (axi_wvalid && axi_wready) r_beat <= axi_wlast ? '0 : r_beat + AXI_LEN_WIDTH'(1);
      end
   end

   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp] <= {r_last, r_alen};

endmodule

// File: tb/tb_axis_waddr_arbiter.sv
// tb_axis_waddr_arbiter: scoreboard bench; expected grants, addresses and beats are queued as
// stimulus is issued and popped as the DUT handshakes them.
module tb_axis_waddr_arbiter;
   localparam int NB = 4;
   localparam int LW = 8;
   localparam int AW = 32;
   localparam int DW = 256;

   typedef struct packed {logic [AW-1:0] addr; logic [LW-1:0] len;} req_t;
   typedef struct packed {logic [7:0] port; logic [DW-1:0] data; logic last;} beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic [NB*AW-1:0] req_aaddr = '0;
   logic [NB*LW-1:0] req_alen = '0;
   logic [NB-1:0]    req_avalid = '0;
   logic [NB-1:0]    req_aready;
   logic [NB*DW-1:0] req_wdata = '0;
   logic [NB-1:0]    req_wvalid = '0;
   logic [NB-1:0]    req_wready;
   logic [AW-1:0]    axi_aaddr;
   logic [LW-1:0]    axi_alen;
   logic             axi_avalid;
   logic             axi_aready = 1'b0;
   logic [DW-1:0]    axi_wdata;
   logic             axi_wlast;
   logic             axi_wvalid;
   logic             axi_wready = 1'b0;

   axis_waddr_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req_aaddr(req_aaddr), .req_alen(req_alen), .req_avalid(req_avalid), .req_aready(req_aready),
      .req_wdata(req_wdata), .req_wvalid(req_wvalid), .req_wready(req_wready),
      .axi_aaddr(axi_aaddr), .axi_alen(axi_alen), .axi_avalid(axi_avalid), .axi_aready(axi_aready),
      .axi_wdata(axi_wdata), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready)
   );

   always #5 clk = ~clk;

   req_t  aq [NB][$];
   req_t  dq [NB][$];
   int    beat [NB];
   int    exp_gnt [$];
   req_t  exp_addr [$];
   beat_t exp_beat [$];

   logic ar_en, wr_en;
   logic [NB-1:0] wv_en;
   logic [NB-1:0] o_aready, o_wready;
   logic o_avalid, o_wvalid, o_wlast, o_wfire, prev_gnt;
   logic [AW-1:0] o_aaddr;
   logic [LW-1:0] o_alen;
   int n_checks = 0, n_errors = 0, n_acc = 0, n_done = 0, n_beats = 0;

   function automatic logic [DW-1:0] bdata(input int p, input logic [AW-1:0] a, input int b);
      return {32'hA500_0000 | 32'(p), a, 32'(b), {5{a ^ 32'(b * 7 + 1)}}};
   endfunction

   // queue a request on port p and its expected grant, address and beats, in call order
   task automatic burst(input int p, input logic [AW-1:0] a, input logic [LW-1:0] l);
      req_t r;
      beat_t eb;
      r.addr = a;
      r.len  = l;
      aq[p].push_back(r);
      exp_gnt.push_back(p);
      exp_addr.push_back(r);
      for (int b = 0; b <= int'(l); b++) begin
         eb.port = 8'(p);
         eb.data = bdata(p, a, b);
         eb.last = (b == int'(l));
         exp_beat.push_back(eb);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < NB; i++) begin
         aq[i].delete();
         dq[i].delete();
         beat[i] = 0;
      end
      exp_gnt.delete();
      exp_addr.delete();
      exp_beat.delete();
      req_avalid = '0; req_wvalid = '0; req_aaddr = '0; req_alen = '0; req_wdata = '0;
      axi_aready = 1'b0; axi_wready = 1'b0;
      ar_en = 1'b1; wr_en = 1'b1; wv_en = '1;
      o_aready = '0; o_wready = '0; o_avalid = 1'b0; o_wvalid = 1'b0; o_wlast = 1'b0; o_wfire = 1'b0;
      o_aaddr = '0; o_alen = '0;
      prev_gnt = 1'b0; n_acc = 0; n_done = 0; n_beats = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_model();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // one clock: drive writers from the model at negedge, sample, score handshakes, advance model
   task automatic step();
      beat_t eb;
      req_t ea;
      int p;
      for (int i = 0; i < NB; i++) begin
         req_avalid[i] = aq[i].size() > 0;
         req_aaddr[i*AW +: AW] = '0;
         req_alen[i*LW +: LW] = '0;
         if (aq[i].size() > 0) begin
            req_aaddr[i*AW +: AW] = aq[i][0].addr;
            req_alen[i*LW +: LW] = aq[i][0].len;
         end
         req_wvalid[i] = dq[i].size() > 0 && wv_en[i];
         req_wdata[i*DW +: DW] = '0;
         if (dq[i].size() > 0) req_wdata[i*DW +: DW] = bdata(i, dq[i][0].addr, beat[i]);
      end
      axi_aready = ar_en;
      axi_wready = wr_en;
      #1;
      o_aready = req_aready; o_wready = req_wready; o_avalid = axi_avalid; o_wvalid = axi_wvalid;
      o_wlast = axi_wlast; o_aaddr = axi_aaddr; o_alen = axi_alen;
      o_wfire = axi_wvalid && axi_wready;
      if (prev_gnt) begin
         n_checks++;
         if (o_avalid !== 1'b1) begin
            n_errors++;
            $display("FAIL addr_latency: axi_avalid=%b cycle after grant, required 1", o_avalid);
         end
      end
      if (|o_aready) begin
         n_checks++;
         if (exp_gnt.size() == 0) begin
            n_errors++;
            $display("FAIL grant: req_aready=%b, required none", o_aready);
         end else begin
            p = exp_gnt.pop_front();
            if (o_aready !== (NB'(1) << p)) begin
               n_errors++;
               $display("FAIL grant: req_aready=%b, required %b", o_aready, NB'(1) << p);
            end
         end
         for (int i = 0; i < NB; i++)
            if (o_aready[i] && aq[i].size() > 0) dq[i].push_back(aq[i].pop_front());
      end
      if (o_wfire) begin
         n_checks++;
         n_beats++;
         if (exp_beat.size() == 0) begin
            n_errors++;
            $display("FAIL beat: unexpected beat data=%h", axi_wdata);
         end else begin
            eb = exp_beat.pop_front();
            if (axi_wdata !== eb.data || o_wlast !== eb.last || o_wready !== (NB'(1) << eb.port) || n_acc <= n_done) begin
               n_errors++;
               $display("FAIL beat: got req_wready=%b wlast=%b data=%h acc=%0d done=%0d, required req_wready=%b wlast=%b data=%h",
                        o_wready, o_wlast, axi_wdata, n_acc, n_done, NB'(1) << eb.port, eb.last, eb.data);
            end
         end
         if (o_wlast) n_done++;
         for (int i = 0; i < NB; i++)
            if (o_wready[i] && req_wvalid[i] && dq[i].size() > 0) begin
               beat[i]++;
               if (beat[i] > int'(dq[i][0].len)) begin
                  void'(dq[i].pop_front());
                  beat[i] = 0;
               end
            end
      end
      if (o_avalid && ar_en) begin
         n_checks++;
         n_acc++;
         if (exp_addr.size() == 0) begin
            n_errors++;
            $display("FAIL addr: unexpected issue addr=%h len=%0d", o_aaddr, o_alen);
         end else begin
            ea = exp_addr.pop_front();
            if (o_aaddr !== ea.addr || o_alen !== ea.len) begin
               n_errors++;
               $display("FAIL addr: got addr=%h len=%0d, required addr=%h len=%0d", o_aaddr, o_alen, ea.addr, ea.len);
            end
         end
      end
      prev_gnt = |o_aready;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_idle(input string name, input int max);
      int n = 0;
      while ((exp_gnt.size() != 0 || exp_addr.size() != 0 || exp_beat.size() != 0) && n < max) begin
         step();
         n++;
      end
      n_checks++;
      if (exp_gnt.size() != 0 || exp_addr.size() != 0 || exp_beat.size() != 0) begin
         n_errors++;
         $display("FAIL %s drain: %0d grants %0d addrs %0d beats outstanding, required 0", name,
                  exp_gnt.size(), exp_addr.size(), exp_beat.size());
      end
   endtask

   task automatic test_reset();
      clear_model();
      #2 rst_n = 1'b0;
      req_avalid = '1; req_wvalid = '1; req_wdata = '1; req_aaddr = '1; req_alen = '1;
      axi_aready = 1'b1; axi_wready = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (req_aready !== '0 || req_wready !== '0) begin
         n_errors++;
         $display("FAIL reset_ready: req_aready=%b req_wready=%b, required 0 0", req_aready, req_wready);
      end
      n_checks++;
      if (axi_aaddr !== '0 || axi_alen !== '0 || axi_avalid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_addr: aaddr=%h alen=%0d avalid=%b, required 0", axi_aaddr, axi_alen, axi_avalid);
      end
      n_checks++;
      if (axi_wdata !== '0 || axi_wlast !== 1'b0 || axi_wvalid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_data: wdata=%h wlast=%b wvalid=%b, required 0", axi_wdata, axi_wlast, axi_wvalid);
      end
      clear_model();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      burst(2, 32'h1000_0000, 8'd255);
      run_idle("single", 400);
      n_checks++;
      if (n_beats !== 256 || n_done !== 1) begin
         n_errors++;
         $display("FAIL single_count: beats=%0d bursts=%0d, required 256 1", n_beats, n_done);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int r = 0; r < 2; r++) begin
         burst(0, 32'h0000_1000 + 32'(r * 'h100), 8'd3);
         burst(1, 32'h0001_1000 + 32'(r * 'h100), 8'd3);
         burst(3, 32'h0003_1000 + 32'(r * 'h100), 8'd3);
      end
      run_idle("round_robin", 200);
   endtask

   task automatic test_aready_stall();
      do_reset();
      ar_en = 1'b0;
      burst(1, 32'h4000_0100, 8'd0);
      burst(2, 32'h4000_0200, 8'd0);
      for (int i = 0; i < 4 && !o_avalid; i++) step();
      for (int i = 0; i < 10; i++) begin
         step();
         n_checks++;
         if (o_avalid !== 1'b1 || o_aaddr !== 32'h4000_0100 || o_alen !== 8'd0 || o_aready !== '0) begin
            n_errors++;
            $display("FAIL stall: avalid=%b addr=%h len=%0d req_aready=%b, required 1 40000100 0 0000",
                     o_avalid, o_aaddr, o_alen, o_aready);
         end
      end
      ar_en = 1'b1;
      run_idle("stall", 50);
   endtask

   task automatic test_fifo_full();
      do_reset();
      wr_en = 1'b0;
      for (int r = 0; r < 3; r++)
         for (int p = 0; p < NB; p++)
            if (r < 2 || p == 0) burst(p, 32'h5000_0000 + 32'(r * 'h1000 + p * 'h10), 8'd0);
      for (int i = 0; i < 30; i++) step();
      n_checks++;
      if (n_acc !== 8 || aq[0].size() !== 1 || o_aready !== '0) begin
         n_errors++;
         $display("FAIL fifo_full: issued=%0d pending=%0d req_aready=%b, required 8 1 0000", n_acc, aq[0].size(), o_aready);
      end
      wr_en = 1'b1;
      step();
      wr_en = 1'b0;
      step();
      n_checks++;
      if (o_aready !== 4'b0001) begin
         n_errors++;
         $display("FAIL fifo_regrant: req_aready=%b, required 0001", o_aready);
      end
      wr_en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         n_checks++;
         if (o_wfire !== 1'b1) begin
            n_errors++;
            $display("FAIL back_to_back: beat %0d fire=%b, required 1", i, o_wfire);
         end
      end
      run_idle("fifo_full", 50);
   endtask

   task automatic test_head_block();
      do_reset();
      wv_en = 4'b1110;
      burst(0, 32'h6000_0000, 8'd3);
      burst(1, 32'h6100_0000, 8'd1);
      for (int i = 0; i < 10 && n_acc < 2; i++) step();
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (o_wvalid !== 1'b0 || o_wready !== 4'b0001) begin
            n_errors++;
            $display("FAIL head_block: wvalid=%b req_wready=%b, required 0 0001", o_wvalid, o_wready);
         end
      end
      wv_en = '1;
      run_idle("head_block", 50);
   endtask

   task automatic test_reset_mid();
      do_reset();
      burst(0, 32'h2000_0000, 8'd255);
      for (int i = 0; i < 300 && n_beats < 100; i++) step();
      n_checks++;
      if (n_beats !== 100) begin
         n_errors++;
         $display("FAIL reset_mid_setup: beats=%0d, required 100", n_beats);
      end
      req_avalid = '1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (req_aready !== '0 || req_wready !== '0 || axi_avalid !== 1'b0 || axi_wvalid !== 1'b0 ||
          axi_wlast !== 1'b0 || axi_wdata !== '0 || axi_aaddr !== '0 || axi_alen !== '0) begin
         n_errors++;
         $display("FAIL reset_mid: aready=%b wready=%b avalid=%b wvalid=%b wlast=%b aaddr=%h alen=%0d, required all 0",
                  req_aready, req_wready, axi_avalid, axi_wvalid, axi_wlast, axi_aaddr, axi_alen);
      end
      clear_model();
      @(negedge clk);
      rst_n = 1'b1;
      burst(0, 32'h3000_0040, 8'd3);
      run_idle("reset_mid", 50);
      n_checks++;
      if (n_beats !== 4 || n_done !== 1) begin
         n_errors++;
         $display("FAIL reset_mid_after: beats=%0d bursts=%0d, required 4 1", n_beats, n_done);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_aready_stall();
      test_fifo_full();
      test_head_block();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
